// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and constants for the register write arbiter.
package reg_write_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    // Width of the committed-write counter
    localparam int CNT_W = 16;

    // Index width needed to address n requesters (at least one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: scans from last+1 upward (wrapping)
// and reports the first requester with its req bit set.
module rr_pick
    import reg_write_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    // First set request at or after last+1, wrapping modulo N_REQ
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!valid && req[(int'(last) + k) % N_REQ]) begin
                valid  = 1'b1;
                winner = IDX_W'((int'(last) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a
// shared register. Each transaction is IDLE -> GRANT -> ACK, so commits are
// at least three cycles apart. A requester that drops req during GRANT
// aborts without touching the register.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       q,
    output logic                   busy,
    output logic [CNT_W-1:0]       wr_count
);

    localparam int IDX_W = idx_width(N_REQ);

    state_t           state;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] last;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_winner;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // Busy follows the state directly so reset clears it without a clock
    assign busy = (state != IDLE);

    // Transaction FSM with registered grant/ack, shared register and counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            winner   <= '0;
            last     <= IDX_W'(N_REQ - 1);
            gnt      <= '0;
            ack      <= '0;
            q        <= '0;
            wr_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (pick_valid) begin
                        winner <= pick_winner;
                        gnt    <= onehot(pick_winner);
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    gnt  <= '0;
                    last <= winner;
                    if (req[winner]) begin
                        q        <= wdata[int'(winner)*WIDTH +: WIDTH];
                        wr_count <= wr_count + 1'b1;
                        ack      <= onehot(winner);
                        state    <= ACK;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACK: begin
                    ack   <= '0;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    ack   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
